prbs32_checker: RTL and testbench

- Receive-side companion to the 32-bit pseudo-random word generator.
- Self-synchronises to an incoming 32-bit LFSR word stream and checks every subsequent word against the locally predicted sequence.
- Reports lock status, per-word error pulses and a saturating error count.
- Sits at the sink end of a link or memory under test; the generator drives the source end.

---
 rtl/prbs32_checker.sv | 191 +++++++++++++++++++
 tb/tb_prbs32_checker.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs32_checker.sv
// Self-synchronising checker for a 32-bit PRBS word stream (x^32+x^22+x^2+x+1).
// Optional PRBS32_BITERR_EN adds a saturating bit-error counter output.
module prbs32_checker #(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_valid,
  input  logic [31:0]      data_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err,
  output logic             sticky_err,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_o
`ifdef PRBS32_BITERR_EN
  ,
  output logic [31:0]      bit_err_count
`endif
);

  typedef enum logic [1:0] {
    StHunt   = 2'b00,
    StVerify = 2'b01,
    StLocked = 2'b10
  } state_e;

  localparam logic [7:0] LockCnt = 8'(LOCK_COUNT);
  localparam logic [7:0] LossCnt = 8'(LOSS_COUNT);

  function automatic logic [31:0] prbs_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      expected_q, expected_d;
  logic [7:0]       match_cnt_q, match_cnt_d;
  logic [7:0]       miss_cnt_q, miss_cnt_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             match;
  logic [7:0]       match_inc;
  logic [7:0]       miss_inc;
  logic [ERR_W-1:0] err_count_inc;

  assign match         = (data_in == expected_q);
  assign match_inc     = match_cnt_q + 8'd1;
  assign miss_inc      = miss_cnt_q + 8'd1;
  assign err_count_inc = (err_count_q == {ERR_W{1'b1}}) ? err_count_q
                                                        : err_count_q + ERR_W'(1);

`ifdef PRBS32_BITERR_EN
  logic [31:0] bit_err_q, bit_err_d;
  logic [31:0] diff;
  logic [5:0]  pop;
  logic [32:0] bit_sum;
  logic [31:0] bit_sat;

  assign diff = data_in ^ expected_q;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 32; i++) begin
      pop = pop + {5'd0, diff[i]};
    end
  end

  assign bit_sum = {1'b0, bit_err_q} + {27'd0, pop};
  assign bit_sat = bit_sum[32] ? 32'hFFFF_FFFF : bit_sum[31:0];
`endif

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    err_d       = 1'b0;
    sticky_d    = sticky_q;
    err_count_d = err_count_q;
`ifdef PRBS32_BITERR_EN
    bit_err_d   = bit_err_q;
`endif

    if (clr_err) begin
      sticky_d    = 1'b0;
      err_count_d = '0;
`ifdef PRBS32_BITERR_EN
      bit_err_d   = '0;
`endif
    end

    if (data_valid) begin
      unique case (state_q)
        StHunt: begin
          if (data_in != 32'd0) begin
            expected_d  = prbs_next(data_in);
            match_cnt_d = '0;
            state_d     = StVerify;
          end
        end

        StVerify: begin
          if (match) begin
            match_cnt_d = match_inc;
            expected_d  = prbs_next(data_in);
            if (match_inc >= LockCnt) begin
              state_d    = StLocked;
              locked_d   = 1'b1;
              miss_cnt_d = '0;
            end
          end else if (data_in != 32'd0) begin
            expected_d  = prbs_next(data_in);
            match_cnt_d = '0;
          end else begin
            state_d = StHunt;
          end
        end

        StLocked: begin
          // Flywheel on our own prediction so a bad word cannot poison later ones.
          expected_d = prbs_next(expected_q);
          if (match) begin
            miss_cnt_d = '0;
          end else begin
            err_d       = 1'b1;
            sticky_d    = 1'b1;
            err_count_d = clr_err ? ERR_W'(1) : err_count_inc;
`ifdef PRBS32_BITERR_EN
            bit_err_d   = clr_err ? {26'd0, pop} : bit_sat;
`endif
            miss_cnt_d  = miss_inc;
            if (miss_inc >= LossCnt) begin
              state_d    = StHunt;
              locked_d   = 1'b0;
              miss_cnt_d = '0;
            end
          end
        end

        default: begin
          state_d  = StHunt;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHunt;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
      err_count_q <= '0;
`ifdef PRBS32_BITERR_EN
      bit_err_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
      err_count_q <= err_count_d;
`ifdef PRBS32_BITERR_EN
      bit_err_q   <= bit_err_d;
`endif
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign sticky_err = sticky_q;
  assign err_count  = err_count_q;
  assign state_o    = state_q;
`ifdef PRBS32_BITERR_EN
  assign bit_err_count = bit_err_q;
`endif

endmodule

// File: tb/tb_prbs32_checker.sv
// Directed bench for prbs32_checker: vector table plus hand-written corner sequences.
module tb_prbs32_checker;

  localparam int unsigned ErrW = 4;

  logic            clk;
  logic            rst_n;
  logic            data_valid;
  logic [31:0]     data_in;
  logic            clr_err;
  logic            locked, err, sticky_err;
  logic [ErrW-1:0] err_count;
  logic [1:0]      state_o;
  logic            locked1, err1, sticky1;
  logic [ErrW-1:0] err_count1;
  logic [1:0]      state1;
`ifdef PRBS32_BITERR_EN
  logic [31:0]     bit_err_count;
  logic [31:0]     bit_err_count1;
`endif

  prbs32_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(ErrW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .data_in    (data_in),
    .clr_err    (clr_err),
    .locked     (locked),
    .err        (err),
    .sticky_err (sticky_err),
    .err_count  (err_count),
    .state_o    (state_o)
`ifdef PRBS32_BITERR_EN
    ,
    .bit_err_count (bit_err_count)
`endif
  );

  // Second instance exercises the LOCK_COUNT=1 boundary on the same stimulus.
  prbs32_checker #(.LOCK_COUNT(1), .LOSS_COUNT(3), .ERR_W(ErrW)) u_dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .data_in    (data_in),
    .clr_err    (clr_err),
    .locked     (locked1),
    .err        (err1),
    .sticky_err (sticky1),
    .err_count  (err_count1),
    .state_o    (state1)
`ifdef PRBS32_BITERR_EN
    ,
    .bit_err_count (bit_err_count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    int          src;    // 0: seq s, 1: seq r, 2: literal
    int          idx;
    logic [31:0] lit;
    logic [31:0] mask;
    logic        clr;
    logic        e_locked;
    logic        e_err;
    logic        e_sticky;
    int          e_cnt;
    logic [1:0]  e_state;
    int          e_l1;   // -1: second instance not checked
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] s_seq[64];
  logic [31:0] r_seq[64];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] lfsr(input logic [31:0] v);
    return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
  endfunction

  function automatic vec_t mk(input logic valid, input int src, input int idx,
                              input logic [31:0] lit, input logic [31:0] mask,
                              input logic clr, input logic e_locked, input logic e_err,
                              input logic e_sticky, input int e_cnt,
                              input logic [1:0] e_state, input int e_l1);
    vec_t v;
    v.valid = valid; v.src = src; v.idx = idx; v.lit = lit; v.mask = mask;
    v.clr = clr; v.e_locked = e_locked; v.e_err = e_err; v.e_sticky = e_sticky;
    v.e_cnt = e_cnt; v.e_state = e_state; v.e_l1 = e_l1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic valid, input logic [31:0] data, input logic clr);
    @(negedge clk);
    data_valid = valid;
    data_in    = data;
    clr_err    = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    int          k;

    s_seq[0] = 32'h0000_0001;
    r_seq[0] = 32'h1234_5678;
    for (int i = 1; i < 64; i++) begin
      s_seq[i] = lfsr(s_seq[i-1]);
      r_seq[i] = lfsr(r_seq[i-1]);
    end

    //           vld src idx lit           mask clr lk er st cnt state  l1
    tbl.push_back(mk(1, 0, 0,  0,            0, 0, 0, 0, 0, 0, 2'b01,  0));
    tbl.push_back(mk(1, 0, 1,  0,            0, 0, 0, 0, 0, 0, 2'b01,  1));
    tbl.push_back(mk(1, 0, 2,  0,            0, 0, 0, 0, 0, 0, 2'b01, -1));
    tbl.push_back(mk(1, 0, 3,  0,            0, 0, 0, 0, 0, 0, 2'b01, -1));
    tbl.push_back(mk(1, 0, 4,  0,            0, 0, 1, 0, 0, 0, 2'b10, -1));
    tbl.push_back(mk(1, 0, 5,  0,            0, 0, 1, 0, 0, 0, 2'b10, -1));
    tbl.push_back(mk(1, 0, 6,  0,            1, 0, 1, 1, 1, 1, 2'b10, -1));
    tbl.push_back(mk(0, 2, 0,  32'hDEAD_BEEF,0, 0, 1, 0, 1, 1, 2'b10, -1));
    tbl.push_back(mk(1, 0, 7,  0,            0, 0, 1, 0, 1, 1, 2'b10, -1));
    tbl.push_back(mk(1, 0, 8,  0,            0, 1, 1, 0, 0, 0, 2'b10, -1));
    tbl.push_back(mk(1, 0, 9,  0,            1, 0, 1, 1, 1, 1, 2'b10, -1));
    tbl.push_back(mk(1, 0, 10, 0,            1, 0, 1, 1, 1, 2, 2'b10, -1));
    tbl.push_back(mk(1, 0, 11, 0,            1, 0, 0, 1, 1, 3, 2'b00, -1));
    tbl.push_back(mk(1, 2, 0,  0,            0, 0, 0, 0, 1, 3, 2'b00, -1));
    tbl.push_back(mk(1, 2, 0,  0,            0, 0, 0, 0, 1, 3, 2'b00, -1));
    tbl.push_back(mk(1, 0, 0,  0,            0, 0, 0, 0, 1, 3, 2'b01, -1));
    tbl.push_back(mk(1, 0, 1,  0,            0, 0, 0, 0, 1, 3, 2'b01, -1));
    tbl.push_back(mk(1, 0, 2,  0,            0, 0, 0, 0, 1, 3, 2'b01, -1));
    tbl.push_back(mk(1, 2, 0,  32'h1234_5678,0, 0, 0, 0, 1, 3, 2'b01, -1));
    tbl.push_back(mk(1, 1, 1,  0,            0, 0, 0, 0, 1, 3, 2'b01, -1));
    tbl.push_back(mk(1, 1, 2,  0,            0, 0, 0, 0, 1, 3, 2'b01, -1));
    tbl.push_back(mk(1, 1, 3,  0,            0, 0, 0, 0, 1, 3, 2'b01, -1));
    tbl.push_back(mk(1, 1, 4,  0,            0, 0, 1, 0, 1, 3, 2'b10, -1));

    rst_n      = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    clr_err    = 1'b0;
    #1;
    check("reset locked", {31'd0, locked}, 0);
    check("reset err", {31'd0, err}, 0);
    check("reset sticky", {31'd0, sticky_err}, 0);
    check("reset count", {28'd0, err_count}, 0);
    check("reset state", {30'd0, state_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      case (tbl[i].src)
        0:       w = s_seq[tbl[i].idx] ^ tbl[i].mask;
        1:       w = r_seq[tbl[i].idx] ^ tbl[i].mask;
        default: w = tbl[i].lit;
      endcase
      apply(tbl[i].valid, w, tbl[i].clr);
      check($sformatf("vec%0d locked", i), {31'd0, locked}, {31'd0, tbl[i].e_locked});
      check($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, tbl[i].e_err});
      check($sformatf("vec%0d sticky", i), {31'd0, sticky_err}, {31'd0, tbl[i].e_sticky});
      check($sformatf("vec%0d count", i), {28'd0, err_count}, tbl[i].e_cnt);
      check($sformatf("vec%0d state", i), {30'd0, state_o}, {30'd0, tbl[i].e_state});
      if (tbl[i].e_l1 >= 0) begin
        check($sformatf("vec%0d lock1", i), {31'd0, locked1}, tbl[i].e_l1);
      end
    end

    // Saturation: 16 isolated errors on a 4-bit counter must stop at 0xF.
    k = 5;
    apply(1'b1, r_seq[k], 1'b1);
    k++;
    check("sat clear", {28'd0, err_count}, 0);
    for (int i = 0; i < 16; i++) begin
      apply(1'b1, r_seq[k] ^ 32'h1, 1'b0);
      k++;
      if (i == 14) check("sat reach", {28'd0, err_count}, 32'hF);
      apply(1'b1, r_seq[k], 1'b0);
      k++;
    end
    check("sat hold", {28'd0, err_count}, 32'hF);
    check("sat locked", {31'd0, locked}, 1);

    // Clear coincident with an error: the error wins.
    apply(1'b1, r_seq[k] ^ 32'h8000_0000, 1'b1);
    k++;
    check("clr+err count", {28'd0, err_count}, 1);
    check("clr+err sticky", {31'd0, sticky_err}, 1);
    check("clr+err pulse", {31'd0, err}, 1);
    apply(1'b1, r_seq[k], 1'b0);
    k++;
    check("flywheel match", {31'd0, err}, 0);

`ifdef PRBS32_BITERR_EN
    apply(1'b1, r_seq[k], 1'b1);
    k++;
    check("bit clr", bit_err_count, 0);
    apply(1'b1, r_seq[k] ^ 32'h1, 1'b0);
    k++;
    check("bit one", bit_err_count, 1);
    apply(1'b1, r_seq[k] ^ 32'hF0, 1'b0);
    k++;
    check("bit five", bit_err_count, 5);
    apply(1'b1, r_seq[k], 1'b0);
    k++;
`endif

    // Async reset mid-LOCKED while an err pulse is showing.
    apply(1'b1, r_seq[k] ^ 32'h1, 1'b0);
    k++;
    check("pre-rst err", {31'd0, err}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst locked", {31'd0, locked}, 0);
    check("rst err", {31'd0, err}, 0);
    check("rst sticky", {31'd0, sticky_err}, 0);
    check("rst count", {28'd0, err_count}, 0);
    check("rst state", {30'd0, state_o}, 0);
    data_valid = 1'b0;
    clr_err    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, r_seq[k], 1'b0);
    check("reseed state", {30'd0, state_o}, 32'h1);
    apply(1'b1, r_seq[k+1], 1'b0);
    check("reseed unlocked", {31'd0, locked}, 0);
    check("reseed state2", {30'd0, state_o}, 32'h1);

    data_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
